// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router types and constants for the output arbiter and allocators
package router_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int FLIT_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts at ptr
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && req[IDX_W'(j)]) begin
                found            = 1'b1;
                gnt[IDX_W'(j)]   = 1'b1;
                gnt_idx          = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sa_output_arbiter.sv
// rtl/sa_output_arbiter.sv - per-output round-robin arbiter with packet lock and credit control
// Optional 16-bit granted-flit counter enabled by SA_FLIT_CNT_EN.
module sa_output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int BUF_DEPTH = 4,
    localparam int IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  tail,
    input  logic                  credit_return,
    output logic [NUM_PORTS-1:0]  grant,
    output logic                  locked,
    output logic [IDX_W-1:0]      owner,
    output logic [CNT_W-1:0]      credit_count,
    output logic                  credit_err,
    output logic [FLIT_CNT_W-1:0] flit_count
);

    arb_state_e           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 can_send;
    logic                 granted;
    logic [IDX_W-1:0]     rr_next;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign can_send = (credit_count != '0);
    assign rr_next  = (arb_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : arb_idx + IDX_W'(1);

    // Gated by the reset level so grant reads zero the instant reset asserts.
    always_comb begin
        grant = '0;
        if (reset && can_send) begin
            if (state == ARB_IDLE) begin
                grant = arb_gnt;
            end else begin
                grant[owner] = req[owner];
            end
        end
    end

    assign granted = |grant;
    assign locked  = (state == ARB_LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (granted) begin
                        rr_ptr <= rr_next;
                        if (!tail[arb_idx]) begin
                            state <= ARB_LOCKED;
                            owner <= arb_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (granted && tail[owner]) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // A grant and a return in the same cycle cancel, so only the unpaired cases move the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_count <= CNT_W'(BUF_DEPTH);
            credit_err   <= 1'b0;
        end else begin
            case ({granted, credit_return})
                2'b10: credit_count <= credit_count - CNT_W'(1);
                2'b01: begin
                    if (credit_count == CNT_W'(BUF_DEPTH)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_count <= credit_count + CNT_W'(1);
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

`ifdef SA_FLIT_CNT_EN
    logic [FLIT_CNT_W-1:0] flit_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_cnt_q <= '0;
        end else if (granted) begin
            flit_cnt_q <= flit_cnt_q + FLIT_CNT_W'(1);
        end
    end

    assign flit_count = flit_cnt_q;
`else
    assign flit_count = '0;
`endif

endmodule

// File: tb/tb_sa_output_arbiter.sv
// tb/tb_sa_output_arbiter.sv - self-checking bench for sa_output_arbiter against a behavioural model
module tb_sa_output_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  tail;
    logic        credit_return;
    logic [3:0]  grant;
    logic        locked;
    logic [1:0]  owner;
    logic [2:0]  credit_count;
    logic        credit_err;
    logic [15:0] flit_count;

    int vectors;
    int miscompares;

    // model state
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    bit          m_err;
    int          m_flits;
    logic [3:0]  exp_grant;
    logic [15:0] exp_flit;

    sa_output_arbiter #(.NUM_PORTS(4), .BUF_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .tail          (tail),
        .credit_return (credit_return),
        .grant         (grant),
        .locked        (locked),
        .owner         (owner),
        .credit_count  (credit_count),
        .credit_err    (credit_err),
        .flit_count    (flit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cnt    = 4;
        m_err    = 0;
        m_flits  = 0;
    endtask

    // Start at posedge+1; return at negedge with expectations computed.
    task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic cr);
        bit found;
        req           = r;
        tail          = t;
        credit_return = cr;
        @(negedge clk);
        exp_grant = 4'b0;
        found     = 0;
        if (m_cnt != 0) begin
            if (m_locked) begin
                if (r[m_owner]) exp_grant[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (!found && r[j]) begin
                        found        = 1;
                        exp_grant[j] = 1'b1;
                    end
                end
            end
        end
`ifdef SA_FLIT_CNT_EN
        exp_flit = 16'(m_flits);
`else
        exp_flit = 16'h0;
`endif
    endtask

    task automatic advance();
        int w;
        bit g;
        g = (exp_grant != 4'b0);
        w = 0;
        for (int i = 0; i < 4; i++) if (exp_grant[i]) w = i;
        @(posedge clk);
        if (g && !m_locked) begin
            m_ptr = (w + 1) % 4;
            if (!tail[w]) begin
                m_locked = 1;
                m_owner  = w;
            end
        end else if (g && m_locked && tail[m_owner]) begin
            m_locked = 0;
        end
        m_cnt = m_cnt - (g ? 1 : 0) + (credit_return ? 1 : 0);
        if (m_cnt > 4) begin
            m_cnt = 4;
            m_err = 1;
        end
        if (g) m_flits = (m_flits + 1) % 65536;
        #1;
    endtask

    task automatic apply_reset();
        req = 4'b0; tail = 4'b0; credit_return = 1'b0;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req = 4'hF; tail = 4'hF; credit_return = 1'b0;
        #1 reset = 1'b0;
        vectors++;
        if (grant !== 4'b0 || locked !== 1'b0 || credit_count !== 3'd4 || credit_err !== 1'b0 || flit_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: grant=%b locked=%b cnt=%0d err=%b flit=%h, want 0000 0 4 0 0000",
                     grant, locked, credit_count, credit_err, flit_count);
        end
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] want_g;
            want_g = (i < 4) ? 4'(1 << i) : 4'b0;
            drive(4'hF, 4'hF, 1'b0);
            vectors++;
            if (grant !== want_g || credit_count !== 3'(4 - i)) begin
                miscompares++;
                $display("FAIL reset_seq[%0d]: grant=%b cnt=%0d, want %b %0d", i, grant, credit_count, want_g, 4 - i);
            end
            advance();
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] want_g [4];
        logic       want_l [4];
        logic [3:0] tails  [4];
        want_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        want_l = '{1'b0, 1'b1, 1'b1, 1'b0};
        tails  = '{4'b0010, 4'b0010, 4'b0011, 4'b0010};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0011, tails[i], 1'b1);
            vectors++;
            if (grant !== want_g[i] || locked !== want_l[i] || credit_count !== 3'd4) begin
                miscompares++;
                $display("FAIL packet_lock[%0d]: grant=%b locked=%b cnt=%0d, want %b %b 4",
                         i, grant, locked, credit_count, want_g[i], want_l[i]);
            end
            advance();
        end
    endtask

    task automatic test_credit_stall();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            vectors++;
            if (grant !== 4'b0001 || credit_count !== 3'(4 - i)) begin
                miscompares++;
                $display("FAIL stall_drain[%0d]: grant=%b cnt=%0d, want 0001 %0d", i, grant, credit_count, 4 - i);
            end
            advance();
        end
        drive(4'b0001, 4'b0000, 1'b1);
        vectors++;
        if (grant !== 4'b0000 || credit_count !== 3'd0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_zero: grant=%b cnt=%0d locked=%b, want 0000 0 1", grant, credit_count, locked);
        end
        advance();
        drive(4'b0001, 4'b0001, 1'b0);
        vectors++;
        if (grant !== 4'b0001 || credit_count !== 3'd1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_resume: grant=%b cnt=%0d locked=%b, want 0001 1 1", grant, credit_count, locked);
        end
        advance();
        drive(4'b0000, 4'b0000, 1'b0);
        vectors++;
        if (locked !== 1'b0 || credit_count !== 3'd0) begin
            miscompares++;
            $display("FAIL stall_end: locked=%b cnt=%0d, want 0 0", locked, credit_count);
        end
        advance();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive(4'b0100, 4'b0100, 1'b1);
        advance();
        drive(4'b0000, 4'b0000, 1'b1);
        vectors++;
        if (credit_count !== 3'd4 || credit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_full: cnt=%0d err=%b, want 4 0", credit_count, credit_err);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 4'b0000, 1'b0);
            vectors++;
            if (credit_err !== 1'b1 || credit_count !== 3'd4) begin
                miscompares++;
                $display("FAIL credit_err_sticky[%0d]: err=%b cnt=%0d, want 1 4", i, credit_err, credit_count);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 4'b1000, 1'b0);
            advance();
        end
        drive(4'b1000, 4'b1000, 1'b1);
        advance();
        drive(4'b0000, 4'b0000, 1'b0);
        vectors++;
        if (credit_count !== 3'd1) begin
            miscompares++;
            $display("FAIL simul_low: cnt=%0d, want 1", credit_count);
        end
        advance();
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(4'b0010, 4'b0000, 1'b0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0010, 4'b0000, 1'b0);
            advance();
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0 || locked !== 1'b0 || credit_count !== 3'd4) begin
            miscompares++;
            $display("FAIL async_reset: grant=%b locked=%b cnt=%0d, want 0000 0 4", grant, locked, credit_count);
        end
        #1 reset = 1'b1;
        model_reset();
        drive(4'hF, 4'hF, 1'b0);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL async_rr_ptr: grant=%b, want 0001", grant);
        end
        advance();
    endtask

    task automatic test_flit_count();
        apply_reset();
`ifdef SA_FLIT_CNT_EN
        force dut.flit_cnt_q = 16'hFFFE;
        #1 release dut.flit_cnt_q;
        m_flits = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 4'b0001, 1'b1);
            advance();
            vectors++;
            if (flit_count !== 16'(32'hFFFF + i)) begin
                miscompares++;
                $display("FAIL flit_wrap[%0d]: flit_count=%h, want %h", i, flit_count, 16'(32'hFFFF + i));
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 4'b0001, 1'b1);
            advance();
            vectors++;
            if (flit_count !== 16'h0) begin
                miscompares++;
                $display("FAIL flit_off[%0d]: flit_count=%h, want 0000", i, flit_count);
            end
        end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            logic [3:0] t;
            logic       cr;
            r  = 4'($urandom);
            t  = 4'($urandom);
            cr = ($urandom_range(0, 9) < 4);
            drive(r, t, cr);
            vectors++;
            if (grant !== exp_grant || locked !== m_locked || credit_count !== 3'(m_cnt) ||
                credit_err !== m_err || flit_count !== exp_flit ||
                (m_locked && owner !== 2'(m_owner))) begin
                miscompares++;
                $display("FAIL random[%0d]: grant=%b locked=%b owner=%0d cnt=%0d err=%b flit=%h, want %b %b %0d %0d %b %h",
                         n, grant, locked, owner, credit_count, credit_err, flit_count,
                         exp_grant, m_locked, m_owner, m_cnt, m_err, exp_flit);
            end
            advance();
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        req           = 4'b0;
        tail          = 4'b0;
        credit_return = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_packet_lock();
        test_credit_stall();
        test_simultaneous();
        test_async_reset();
        test_flit_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
